// File: rtl/p3_pkg.sv
// Shared types and codes for the p3 execute sequencer.
// Imported by the shift/ALU and the sequencer.
package p3_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_A = 3'd1,
        S_LOAD_B = 3'd2,
        S_EXEC   = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;

    localparam logic [1:0] SH_NONE = 2'b00;
    localparam logic [1:0] SH_LSL  = 2'b01;
    localparam logic [1:0] SH_LSR  = 2'b10;
    localparam logic [1:0] SH_ASR  = 2'b11;

endpackage

// File: rtl/p3_regfile.sv
// 8x16 register file: one combinational read port, one synchronous write port.
// Contents are not reset; software initialises what it reads.
module p3_regfile #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic [DATA_W-1:0] data_in,
    input  logic [REG_AW-1:0] writenum,
    input  logic              write,
    input  logic [REG_AW-1:0] readnum,
    output logic [DATA_W-1:0] data_out
);

    logic [DATA_W-1:0] regs_q [2**REG_AW];

    always_ff @(posedge clk) begin
        if (write) regs_q[writenum] <= data_in;
    end

    assign data_out = regs_q[readnum];

endmodule

// File: rtl/p3_shift_alu.sv
// Combinational B-shifter followed by the ALU and flag generation.
// V is meaningful only for ADD/SUB and is forced low otherwise.
module p3_shift_alu
    import p3_pkg::*;
#(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [1:0]   shift,
    input  logic [1:0]   op,
    output logic [W-1:0] result,
    output logic         z,
    output logic         n,
    output logic         v
);

    logic [W-1:0] bs;
    logic [W-1:0] sum;
    logic [W-1:0] diff;

    always_comb begin
        bs = b;
        unique case (shift)
            SH_NONE: bs = b;
            SH_LSL:  bs = {b[W-2:0], 1'b0};
            SH_LSR:  bs = {1'b0, b[W-1:1]};
            SH_ASR:  bs = {b[W-1], b[W-1:1]};
            default: bs = b;
        endcase
    end

    assign sum  = a + bs;
    assign diff = a - bs;

    always_comb begin
        result = '0;
        v      = 1'b0;
        unique case (op)
            ALU_ADD: begin
                result = sum;
                v = (a[W-1] == bs[W-1]) && (sum[W-1] != a[W-1]);
            end
            ALU_SUB: begin
                result = diff;
                v = (a[W-1] != bs[W-1]) && (diff[W-1] != a[W-1]);
            end
            ALU_AND:  result = a & bs;
            ALU_NOTB: result = ~bs;
            default:  result = '0;
        endcase
    end

    assign z = (result == '0);
    assign n = result[W-1];

endmodule

// File: rtl/p3_exec_unit.sv
// Operand-fetch / execute / write-back sequencer around p3_regfile.
// One operation takes six cycles from acceptance back to IDLE.
module p3_exec_unit #(
    parameter int DATA_W = p3_pkg::DATA_W,
    parameter int REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [1:0]        op,
    input  logic [1:0]        shift,
    input  logic [REG_AW-1:0] rn,
    input  logic [REG_AW-1:0] rm,
    input  logic [REG_AW-1:0] rd,
    input  logic [DATA_W-1:0] rf_data_out,
    output logic [REG_AW-1:0] rf_readnum,
    output logic [REG_AW-1:0] rf_writenum,
    output logic              rf_write,
    output logic [DATA_W-1:0] rf_data_in,
    output logic              busy,
    output logic              done,
    output logic              status_z,
    output logic              status_n,
    output logic              status_v
);

    import p3_pkg::*;

    state_t state_q, state_d;

    logic [1:0]        op_q, shift_q;
    logic [REG_AW-1:0] rn_q, rm_q, rd_q;
    logic [DATA_W-1:0] a_q, b_q, c_q;
    logic              z_q, n_q, v_q;

    logic [DATA_W-1:0] alu_res;
    logic              alu_z, alu_n, alu_v;

    p3_shift_alu #(.W(DATA_W)) u_alu (
        .a      (a_q),
        .b      (b_q),
        .shift  (shift_q),
        .op     (op_q),
        .result (alu_res),
        .z      (alu_z),
        .n      (alu_n),
        .v      (alu_v)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start) state_d = S_LOAD_A;
            S_LOAD_A: state_d = S_LOAD_B;
            S_LOAD_B: state_d = S_EXEC;
            S_EXEC:   state_d = S_WRITE;
            S_WRITE:  state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rf_readnum  = '0;
        rf_writenum = '0;
        rf_write    = 1'b0;
        done        = 1'b0;
        unique case (state_q)
            S_LOAD_A: rf_readnum = rn_q;
            S_LOAD_B: rf_readnum = rm_q;
            S_WRITE: begin
                rf_writenum = rd_q;
                rf_write    = 1'b1;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

    assign busy       = (state_q != S_IDLE);
    assign rf_data_in = c_q;
    assign status_z   = z_q;
    assign status_n   = n_q;
    assign status_v   = v_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q    <= '0;
            shift_q <= '0;
            rn_q    <= '0;
            rm_q    <= '0;
            rd_q    <= '0;
        end else if (state_q == S_IDLE && start) begin
            op_q    <= op;
            shift_q <= shift;
            rn_q    <= rn;
            rm_q    <= rm;
            rd_q    <= rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q <= '0;
            b_q <= '0;
            c_q <= '0;
            z_q <= 1'b0;
            n_q <= 1'b0;
            v_q <= 1'b0;
        end else begin
            if (state_q == S_LOAD_A) a_q <= rf_data_out;
            if (state_q == S_LOAD_B) b_q <= rf_data_out;
            if (state_q == S_EXEC) begin
                c_q <= alu_res;
                z_q <= alu_z;
                n_q <= alu_n;
                v_q <= alu_v;
            end
        end
    end

endmodule

// File: tb/tb_p3_exec_unit.sv
// Directed bench for p3_exec_unit wired to p3_regfile.
// The bench owns the register file ports while the sequencer is idle.
module tb_p3_exec_unit;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  op, shift;
    logic [2:0]  rn, rm, rd;
    logic [15:0] rf_data_out;
    logic [2:0]  rf_readnum, rf_writenum;
    logic        rf_write;
    logic [15:0] rf_data_in;
    logic        busy, done;
    logic        status_z, status_n, status_v;

    logic        tb_we, tb_rsel;
    logic [2:0]  tb_wnum, tb_rnum;
    logic [15:0] tb_din;

    logic [2:0]  m_wnum, m_rnum;
    logic [15:0] m_din;
    logic        m_we;

    int n_cmp;
    int n_bad;

    assign m_we   = rf_write | tb_we;
    assign m_wnum = tb_we ? tb_wnum : rf_writenum;
    assign m_din  = tb_we ? tb_din : rf_data_in;
    assign m_rnum = tb_rsel ? tb_rnum : rf_readnum;

    p3_exec_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .op          (op),
        .shift       (shift),
        .rn          (rn),
        .rm          (rm),
        .rd          (rd),
        .rf_data_out (rf_data_out),
        .rf_readnum  (rf_readnum),
        .rf_writenum (rf_writenum),
        .rf_write    (rf_write),
        .rf_data_in  (rf_data_in),
        .busy        (busy),
        .done        (done),
        .status_z    (status_z),
        .status_n    (status_n),
        .status_v    (status_v)
    );

    p3_regfile u_rf (
        .clk      (clk),
        .data_in  (m_din),
        .writenum (m_wnum),
        .write    (m_we),
        .readnum  (m_rnum),
        .data_out (rf_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rf_set(input logic [2:0] idx, input logic [15:0] val);
        tb_we   = 1'b1;
        tb_wnum = idx;
        tb_din  = val;
        tick();
        tb_we   = 1'b0;
    endtask

    task automatic rf_chk(input string tag, input logic [2:0] idx,
                          input logic [15:0] exp);
        tb_rsel = 1'b1;
        tb_rnum = idx;
        #1;
        chk(tag, rf_data_out, exp);
        tb_rsel = 1'b0;
    endtask

    task automatic go(input logic [1:0] o, input logic [1:0] s,
                      input logic [2:0] a, input logic [2:0] b,
                      input logic [2:0] d);
        op    = o;
        shift = s;
        rn    = a;
        rm    = b;
        rd    = d;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        for (int i = 0; i < 10; i++) begin
            if (done) break;
            tick();
        end
        chk(tag, {15'd0, done}, 16'd1);
        tick();
    endtask

    task automatic flags(input string tag, input logic z, input logic n,
                         input logic v);
        chk(tag, {13'd0, status_z, status_n, status_v}, {13'd0, z, n, v});
    endtask

    initial begin
        n_cmp   = 0;
        n_bad   = 0;
        rst_n   = 1'b0;
        start   = 1'b0;
        op      = 2'b00;
        shift   = 2'b00;
        rn      = 3'd0;
        rm      = 3'd0;
        rd      = 3'd0;
        tb_we   = 1'b0;
        tb_rsel = 1'b0;
        tb_wnum = 3'd0;
        tb_rnum = 3'd0;
        tb_din  = 16'h0;
        tick();
        tick();
        chk("rst_busy", {15'd0, busy}, 16'd0);
        chk("rst_done", {15'd0, done}, 16'd0);
        chk("rst_write", {15'd0, rf_write}, 16'd0);
        chk("rst_din", rf_data_in, 16'h0);
        flags("rst_flags", 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        tick();

        // ADD R0+R1 -> R2, cycle by cycle
        rf_set(3'd0, 16'h0005);
        rf_set(3'd1, 16'h0003);
        go(2'b00, 2'b00, 3'd0, 3'd1, 3'd2);
        chk("t1_busy", {15'd0, busy}, 16'd1);
        chk("t1_rnumA", {13'd0, rf_readnum}, 16'd0);
        tick();
        chk("t1_rnumB", {13'd0, rf_readnum}, 16'd1);
        chk("t1_wrB", {15'd0, rf_write}, 16'd0);
        tick();
        chk("t1_wrX", {15'd0, rf_write}, 16'd0);
        tick();
        chk("t1_wrW", {15'd0, rf_write}, 16'd1);
        chk("t1_wnum", {13'd0, rf_writenum}, 16'd2);
        chk("t1_din", rf_data_in, 16'h0008);
        chk("t1_doneW", {15'd0, done}, 16'd0);
        tick();
        chk("t1_doneD", {15'd0, done}, 16'd1);
        chk("t1_wrD", {15'd0, rf_write}, 16'd0);
        tick();
        chk("t1_doneI", {15'd0, done}, 16'd0);
        chk("t1_busyI", {15'd0, busy}, 16'd0);
        flags("t1_flags", 1'b0, 1'b0, 1'b0);
        rf_chk("t1_R2", 3'd2, 16'h0008);

        // SUB with rn=rm=rd
        rf_set(3'd1, 16'h0003);
        go(2'b01, 2'b00, 3'd1, 3'd1, 3'd1);
        wait_done("t2_done");
        rf_chk("t2_R1", 3'd1, 16'h0000);
        flags("t2_flags", 1'b1, 1'b0, 1'b0);

        // signed overflow on ADD
        rf_set(3'd3, 16'h7FFF);
        rf_set(3'd4, 16'h0001);
        go(2'b00, 2'b00, 3'd3, 3'd4, 3'd5);
        wait_done("t3_done");
        rf_chk("t3_R5", 3'd5, 16'h8000);
        flags("t3_flags", 1'b0, 1'b1, 1'b1);

        // reset during EXEC: no write to R5, everything cleared at once
        go(2'b01, 2'b00, 3'd3, 3'd4, 3'd5);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("rs_busy", {15'd0, busy}, 16'd0);
        chk("rs_done", {15'd0, done}, 16'd0);
        chk("rs_write", {15'd0, rf_write}, 16'd0);
        chk("rs_din", rf_data_in, 16'h0);
        flags("rs_flags", 1'b0, 1'b0, 1'b0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tick();
        chk("rs_done2", {15'd0, done}, 16'd0);
        rf_chk("rs_R5", 3'd5, 16'h8000);

        // ADD with ASR on B
        rf_set(3'd6, 16'h8001);
        rf_set(3'd0, 16'h0000);
        go(2'b00, 2'b11, 3'd0, 3'd6, 3'd7);
        wait_done("t4_done");
        rf_chk("t4_R7", 3'd7, 16'hC000);
        flags("t4_flags", 1'b0, 1'b1, 1'b0);

        // AND with LSL on B
        rf_set(3'd2, 16'hFFFF);
        go(2'b10, 2'b01, 3'd2, 3'd6, 3'd7);
        wait_done("t5_done");
        rf_chk("t5_R7", 3'd7, 16'h0002);
        flags("t5_flags", 1'b0, 1'b0, 1'b0);

        // NOT B with LSR on B
        go(2'b11, 2'b10, 3'd2, 3'd6, 3'd1);
        wait_done("t6_done");
        rf_chk("t6_R1", 3'd1, 16'hBFFF);
        flags("t6_flags", 1'b0, 1'b1, 1'b0);

        // start held high, rd changed after acceptance
        rf_set(3'd0, 16'h0010);
        rf_set(3'd1, 16'h0001);
        op    = 2'b00;
        shift = 2'b00;
        rn    = 3'd0;
        rm    = 3'd1;
        rd    = 3'd3;
        start = 1'b1;
        tick();
        rd = 3'd4;
        chk("t7_busy0", {15'd0, busy}, 16'd1);
        tick();
        tick();
        tick();
        chk("t7_wnum", {13'd0, rf_writenum}, 16'd3);
        tick();
        chk("t7_done", {15'd0, done}, 16'd1);
        tick();
        chk("t7_idle", {15'd0, busy}, 16'd0);
        tick();
        chk("t7_busy6", {15'd0, busy}, 16'd1);
        chk("t7_rnum6", {13'd0, rf_readnum}, 16'd0);
        start = 1'b0;
        wait_done("t7_done2");
        rf_chk("t7_R3", 3'd3, 16'h0011);
        rf_chk("t7_R4", 3'd4, 16'h0011);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
